// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/move conditions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package y86_pkg;

   localparam int W = 64;

   // Instruction codes
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_IADDQ  = 4'hC;

   // ALU functions (low two bits of ifun for OPq)
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   // Branch / conditional-move conditions
   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU: add/sub/and/xor of B op A with zero, sign and overflow flags.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
import y86_pkg::*;

module execute_alu #(
   parameter int W = 64
) (
   input  logic [1:0]   i_fn,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_res,
   output logic         o_zf,
   output logic         o_sf,
   output logic         o_of
);

   // Result and flags; subtraction is B-A, matching the Y86 operand order
   always_comb begin
      o_res = '0;
      o_of  = 1'b0;
      case (i_fn)
         ALU_ADD: begin
            o_res = i_b + i_a;
            o_of  = (i_a[W-1] == i_b[W-1]) && (o_res[W-1] != i_a[W-1]);
         end
         ALU_SUB: begin
            o_res = i_b - i_a;
            o_of  = (i_b[W-1] != i_a[W-1]) && (o_res[W-1] != i_b[W-1]);
         end
         ALU_AND: o_res = i_b & i_a;
         default: o_res = i_b ^ i_a;
      endcase
      o_zf = (o_res == '0);
      o_sf = o_res[W-1];
   end

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: computes ValE, owns the ZF/SF/OF register, evaluates Cnd.
// Latency: ValE/Cnd zero cycles; flags visible the cycle after the updating edge.
// Backpressure: none. Optional iaddq support via macro EXECUTE_IADDQ_EN.
import y86_pkg::*;

module execute #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] ValA,
   input  logic [W-1:0] ValB,
   input  logic [W-1:0] ValC,
   output logic         ZF,
   output logic         SF,
   output logic         OF,
   output logic         Cnd,
   output logic [W-1:0] ValE
);

   logic         r_zf, r_sf, r_of;
   logic [W-1:0] w_alu_a;
   logic [1:0]   w_alu_fn;
   logic [W-1:0] w_alu_res;
   logic         w_alu_zf, w_alu_sf, w_alu_of;
   logic         w_opq_ok;
   logic         w_cc_en;
   logic         w_sf_x_of;

   assign w_opq_ok = (icode == I_OPQ) && (ifun[3:2] == 2'b00);

`ifdef EXECUTE_IADDQ_EN
   // iaddq reuses the adder with ValC in place of ValA
   assign w_alu_a  = (icode == I_IADDQ) ? ValC : ValA;
   assign w_alu_fn = (icode == I_IADDQ) ? ALU_ADD : ifun[1:0];
   assign w_cc_en  = w_opq_ok || (icode == I_IADDQ);
`else
   assign w_alu_a  = ValA;
   assign w_alu_fn = ifun[1:0];
   assign w_cc_en  = w_opq_ok;
`endif

   execute_alu #(.W(W)) u_alu (
      .i_fn  (w_alu_fn),
      .i_a   (w_alu_a),
      .i_b   (ValB),
      .o_res (w_alu_res),
      .o_zf  (w_alu_zf),
      .o_sf  (w_alu_sf),
      .o_of  (w_alu_of)
   );

   // ValE per instruction class; unknown icodes and unused OPq functions give 0
   always_comb begin
      ValE = '0;
      case (icode)
         I_CMOVXX:           ValE = ValA;
         I_IRMOVQ:           ValE = ValC;
         I_RMMOVQ, I_MRMOVQ: ValE = ValB + ValC;
         I_OPQ:              ValE = w_opq_ok ? w_alu_res : '0;
         I_CALL, I_PUSHQ:    ValE = ValB - W'(8);
         I_RET, I_POPQ:      ValE = ValB + W'(8);
`ifdef EXECUTE_IADDQ_EN
         I_IADDQ:            ValE = w_alu_res;
`endif
         default:            ValE = '0;
      endcase
   end

   // Condition-code register; async reset wins over any same-cycle update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zf <= 1'b1;
         r_sf <= 1'b0;
         r_of <= 1'b0;
      end else if (w_cc_en) begin
         r_zf <= w_alu_zf;
         r_sf <= w_alu_sf;
         r_of <= w_alu_of;
      end
   end

   assign ZF = r_zf;
   assign SF = r_sf;
   assign OF = r_of;
   assign w_sf_x_of = r_sf ^ r_of;

   // Branch/move condition from the registered flags; only meaningful for cmov/jXX
   always_comb begin
      Cnd = 1'b0;
      if (icode == I_CMOVXX || icode == I_JXX) begin
         case (ifun)
            C_ALWAYS: Cnd = 1'b1;
            C_LE:     Cnd = w_sf_x_of | r_zf;
            C_L:      Cnd = w_sf_x_of;
            C_E:      Cnd = r_zf;
            C_NE:     Cnd = ~r_zf;
            C_GE:     Cnd = ~w_sf_x_of;
            C_G:      Cnd = ~w_sf_x_of & ~r_zf;
            default:  Cnd = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage with a queue-based scoreboard.
// Stimulus drives just after each rising edge and queues expectations.
// A monitor on the falling edge pops and compares against the DUT outputs.
module tb_execute;

   localparam int W = 64;

   localparam int K_VALE = 0;
   localparam int K_CND  = 1;
   localparam int K_ZF   = 2;
   localparam int K_SF   = 3;
   localparam int K_OF   = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] val;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   icode;
   logic [3:0]   ifun;
   logic [W-1:0] ValA;
   logic [W-1:0] ValB;
   logic [W-1:0] ValC;
   logic         ZF, SF, OF, Cnd;
   logic [W-1:0] ValE;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   execute #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .icode (icode),
      .ifun  (ifun),
      .ValA  (ValA),
      .ValB  (ValB),
      .ValC  (ValC),
      .ZF    (ZF),
      .SF    (SF),
      .OF    (OF),
      .Cnd   (Cnd),
      .ValE  (ValE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every falling edge, drain queued expectations against live outputs
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [63:0] act;
         e = sb.pop_front();
         case (e.kind)
            K_VALE:  act = ValE;
            K_CND:   act = {63'd0, Cnd};
            K_ZF:    act = {63'd0, ZF};
            K_SF:    act = {63'd0, SF};
            default: act = {63'd0, OF};
         endcase
         n_checks++;
         if (act !== e.val) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, act, e.val);
         end
      end
   end

   task automatic expect_val(input string name, input int kind, input logic [63:0] val);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic expect_flags(input string tag, input logic zf, input logic sf, input logic of);
      expect_val({tag, ".ZF"}, K_ZF, {63'd0, zf});
      expect_val({tag, ".SF"}, K_SF, {63'd0, sf});
      expect_val({tag, ".OF"}, K_OF, {63'd0, of});
   endtask

   // Present one instruction just after the next rising edge
   task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      @(posedge clk);
      #1;
      icode = ic;
      ifun  = fn;
      ValA  = a;
      ValB  = b;
      ValC  = c;
   endtask

   initial begin
      // Reset with no edge yet: flags at reset values, halt gives zero
      rst_n = 1'b0;
      icode = 4'h0; ifun = 4'h0; ValA = '0; ValB = '0; ValC = '0;
      expect_val("reset.halt.ValE", K_VALE, 64'd0);
      expect_val("reset.halt.Cnd",  K_CND,  64'd0);
      expect_flags("reset", 1'b1, 1'b0, 1'b0);

      issue(4'h1, 4'h0, 64'd5, 64'd6, 64'd7);
      rst_n = 1'b1;
      expect_val("nop.ValE", K_VALE, 64'd0);
      expect_val("nop.Cnd",  K_CND,  64'd0);

      // subq then cmovl
      issue(4'h6, 4'h1, 64'd800, 64'd600, 64'd0);
      expect_val("subq.ValE", K_VALE, 64'hFFFF_FFFF_FFFF_FF38);
      expect_flags("subq.pre", 1'b1, 1'b0, 1'b0);
      issue(4'h2, 4'h2, 64'd800, 64'd600, 64'd0);
      expect_val("cmovl.ValE", K_VALE, 64'd800);
      expect_val("cmovl.Cnd",  K_CND,  64'd1);
      expect_flags("subq.post", 1'b0, 1'b1, 1'b0);

      // Address / move ops
      issue(4'h3, 4'h0, 64'd0, 64'd0, 64'd699);
      expect_val("irmovq.ValE", K_VALE, 64'd699);
      issue(4'h5, 4'h0, 64'd0, 64'd120, 64'd100);
      expect_val("mrmovq.ValE", K_VALE, 64'd220);
      issue(4'h4, 4'h0, 64'd0, 64'd150, 64'd110);
      expect_val("rmmovq.ValE", K_VALE, 64'd260);
      expect_flags("movs.held", 1'b0, 1'b1, 1'b0);

      // addq then jmp / je
      issue(4'h6, 4'h0, 64'd200, 64'd300, 64'd0);
      expect_val("addq.ValE", K_VALE, 64'd500);
      issue(4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
      expect_val("jmp.Cnd",  K_CND,  64'd1);
      expect_val("jmp.ValE", K_VALE, 64'd0);
      expect_flags("addq.post", 1'b0, 1'b0, 1'b0);
      issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
      expect_val("je.Cnd", K_CND, 64'd0);

      // Stack ops; none of them may touch the flags
      issue(4'h8, 4'h0, 64'd0, 64'd550, 64'd0);
      expect_val("call.ValE", K_VALE, 64'd542);
      issue(4'h9, 4'h0, 64'd0, 64'd450, 64'd0);
      expect_val("ret.ValE", K_VALE, 64'd458);
      issue(4'hA, 4'h0, 64'd0, 64'd500, 64'd0);
      expect_val("pushq.ValE", K_VALE, 64'd492);
      issue(4'hB, 4'h0, 64'd0, 64'd130, 64'd0);
      expect_val("popq.ValE", K_VALE, 64'd138);
      issue(4'h2, 4'h4, 64'd77, 64'd0, 64'd0);
      expect_val("cmovne.ValE", K_VALE, 64'd77);
      expect_val("cmovne.Cnd",  K_CND,  64'd1);
      expect_flags("stack.held", 1'b0, 1'b0, 1'b0);

      // Zero result, then OPq ifun=4 and icode C must hold the flags
      issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
      expect_val("subq0.ValE", K_VALE, 64'd0);
      issue(4'h6, 4'h4, 64'd1, 64'd7, 64'd0);
      expect_val("opq_bad.ValE", K_VALE, 64'd0);
      expect_flags("subq0.post", 1'b1, 1'b0, 1'b0);
      issue(4'hC, 4'h0, 64'd0, 64'd3, 64'd4);
`ifdef EXECUTE_IADDQ_EN
      expect_val("iaddq.ValE", K_VALE, 64'd7);
`else
      expect_val("icodeC.ValE", K_VALE, 64'd0);
`endif
      expect_val("icodeC.Cnd", K_CND, 64'd0);
      expect_flags("opq_bad.held", 1'b1, 1'b0, 1'b0);
      issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
`ifdef EXECUTE_IADDQ_EN
      expect_val("je.after_c.Cnd", K_CND, 64'd0);
      expect_flags("iaddq.post", 1'b0, 1'b0, 1'b0);
`else
      expect_val("je.after_c.Cnd", K_CND, 64'd1);
      expect_flags("icodeC.held", 1'b1, 1'b0, 1'b0);
`endif

      // andq, xorq
      issue(4'h6, 4'h2, 64'h00F0, 64'h003C, 64'd0);
      expect_val("andq.ValE", K_VALE, 64'h0030);
      issue(4'h6, 4'h3, 64'h00FF, 64'h00FF, 64'd0);
      expect_val("xorq.ValE", K_VALE, 64'd0);
      expect_flags("andq.post", 1'b0, 1'b0, 1'b0);
      issue(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
      expect_val("cond7.Cnd", K_CND, 64'd0);
      expect_flags("xorq.post", 1'b1, 1'b0, 1'b0);

      // Add overflow
      issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      expect_val("addovf.ValE", K_VALE, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
      expect_val("jle.Cnd", K_CND, 64'd0);
      expect_flags("addovf.post", 1'b0, 1'b1, 1'b1);
      issue(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
      expect_val("jg.Cnd", K_CND, 64'd1);

      // Sub overflow: MIN - 1
      issue(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
      expect_val("subovf.ValE", K_VALE, 64'h7FFF_FFFF_FFFF_FFFF);
      issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
      expect_val("jl.Cnd", K_CND, 64'd1);
      expect_flags("subovf.post", 1'b0, 1'b0, 1'b1);
      issue(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
      expect_val("jge.Cnd", K_CND, 64'd0);

      // Reset mid-operation beats a same-edge flag update; ValE stays live
      issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      rst_n = 1'b0;
      expect_val("rstmid.ValE", K_VALE, 64'hFFFF_FFFF_FFFF_FFFE);
      expect_flags("rstmid.now", 1'b1, 1'b0, 1'b0);
      issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
      expect_flags("rstmid.edge", 1'b1, 1'b0, 1'b0);
      issue(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
      rst_n = 1'b1;
      expect_flags("rstmid.release", 1'b1, 1'b0, 1'b0);

      // Let the monitor drain the last entries
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
